// File: rtl/input_sel_pkg.sv
// ============================================================================
// Module   : input_sel_pkg
// Brief    : State encoding and default parameter values for input_failover_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package input_sel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRI  = 2'd1,
        SEC  = 2'd2,
        HOLD = 2'd3
    } fo_state_t;

    localparam int unsigned C_WIN_LOG2     = 8;
    localparam int unsigned C_MIN_EDGES    = 4;
    localparam int unsigned C_GOOD_WINDOWS = 4;
    localparam int unsigned C_HOLDOFF      = 64;

endpackage

`default_nettype wire

// File: rtl/edge_window_counter.sv
// ============================================================================
// Module   : edge_window_counter
// Brief    : Rising-edge counter for one serial input, evaluated per window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_window_counter #(
    parameter int unsigned MIN_EDGES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    input  logic we_i,
    output logic active_now_o,
    output logic active_o
);

    logic       prev_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_tot_w;
    logic       rise_w;
    logic       active_q;

    assign rise_w = sig_i & ~prev_q;

    // An edge landing on the window-end cycle still belongs to the closing window.
    assign cnt_tot_w    = (cnt_q == 8'hFF) ? 8'hFF : (cnt_q + {7'd0, rise_w});
    assign active_now_o = (cnt_tot_w >= 8'(MIN_EDGES));
    assign cnt_d        = we_i ? 8'd0 : cnt_tot_w;
    assign active_o     = active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= 1'b0;
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            cnt_q  <= cnt_d;
            if (we_i) begin
                active_q <= active_now_o;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/input_failover_ctrl.sv
// ============================================================================
// Module   : input_failover_ctrl
// Brief    : Primary/secondary serial input supervisor with holdoff-guarded
//            failover and failback. Define FAILOVER_IRQ_EN to build irq and
//            switch_cnt logic; otherwise both outputs are tied to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module input_failover_ctrl
    import input_sel_pkg::*;
#(
    parameter int unsigned WIN_LOG2     = C_WIN_LOG2,
    parameter int unsigned MIN_EDGES    = C_MIN_EDGES,
    parameter int unsigned GOOD_WINDOWS = C_GOOD_WINDOWS,
    parameter int unsigned HOLDOFF      = C_HOLDOFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in0,
    input  logic       in1,
    input  logic       testmode,
    output logic       out,
    output logic       out_valid,
    output logic       in0selected,
    output logic [1:0] state,
    output logic [1:0] active,
    output logic       irq,
    output logic [7:0] switch_cnt
);

    logic [WIN_LOG2-1:0] win_cnt_q;
    logic                we_w;
    logic                a0_w, a1_w;
    logic                act0_w, act1_w;

    fo_state_t  state_q, state_d;
    logic       sel_q, sel_d;
    logic [3:0] good_q, good_d;
    logic [7:0] hold_q, hold_d;
    logic       enter_hold_w;
    logic       out_q;
    logic       valid_d_w;
    logic       eff_d_w;

    assign we_w = &win_cnt_q;

    edge_window_counter #(.MIN_EDGES(MIN_EDGES)) u_ewc0 (
        .clk          (clk),
        .rst          (rst),
        .sig_i        (in0),
        .we_i         (we_w),
        .active_now_o (a0_w),
        .active_o     (act0_w)
    );

    edge_window_counter #(.MIN_EDGES(MIN_EDGES)) u_ewc1 (
        .clk          (clk),
        .rst          (rst),
        .sig_i        (in1),
        .we_i         (we_w),
        .active_now_o (a1_w),
        .active_o     (act1_w)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        good_d       = good_q;
        hold_d       = hold_q;
        enter_hold_w = 1'b0;
        case (state_q)
            IDLE: begin
                if (we_w) begin
                    if (a0_w) begin
                        state_d = PRI;
                        sel_d   = 1'b0;
                    end else if (a1_w) begin
                        state_d = SEC;
                        sel_d   = 1'b1;
                    end
                end
            end
            PRI: begin
                if (we_w && !a0_w) begin
                    if (a1_w) begin
                        enter_hold_w = 1'b1;
                        sel_d        = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SEC: begin
                if (we_w) begin
                    if (a0_w) begin
                        if ((good_q + 4'd1) == 4'(GOOD_WINDOWS)) begin
                            enter_hold_w = 1'b1;
                            sel_d        = 1'b0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else begin
                        good_d = 4'd0;
                        if (!a1_w) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            HOLD: begin
                // Window ends are deliberately ignored here, including one on the expiry cycle.
                hold_d = hold_q + 8'd1;
                if (hold_q == 8'(HOLDOFF - 1)) begin
                    state_d = sel_q ? SEC : PRI;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_hold_w) begin
            state_d = HOLD;
            good_d  = 4'd0;
            hold_d  = 8'd0;
        end
    end

    assign valid_d_w = (state_d != IDLE);
    assign eff_d_w   = sel_d ^ testmode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q <= '0;
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            good_q    <= 4'd0;
            hold_q    <= 8'd0;
            out_q     <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
            state_q   <= state_d;
            sel_q     <= sel_d;
            good_q    <= good_d;
            hold_q    <= hold_d;
            out_q     <= valid_d_w & (eff_d_w ? in1 : in0);
        end
    end

    assign out         = out_q;
    assign out_valid   = (state_q != IDLE);
    assign in0selected = out_valid & ~(sel_q ^ testmode);
    assign state       = state_q;
    assign active      = {act1_w, act0_w};

`ifdef FAILOVER_IRQ_EN
    logic       irq_q;
    logic [7:0] swcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= 1'b0;
            swcnt_q <= 8'd0;
        end else begin
            irq_q <= enter_hold_w;
            if (enter_hold_w && (swcnt_q != 8'hFF)) begin
                swcnt_q <= swcnt_q + 8'd1;
            end
        end
    end

    assign irq        = irq_q;
    assign switch_cnt = swcnt_q;
`else
    assign irq        = 1'b0;
    assign switch_cnt = 8'd0;
`endif

endmodule

`default_nettype wire
